// File: rtl/up_core_vec_if.sv
// up_core_vec_if: program-load, interrupt and status bundle of up_core_vec.
// master drives run/load/int lines; slave (the core) returns ack, halt, pc.
interface up_core_vec_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int INT_N  = 4
);
  logic              run_i;
  logic              ld_we_i;
  logic [ADDR_W-1:0] ld_addr_i;
  logic [DATA_W-1:0] ld_data_i;
  logic [INT_N-1:0]  int_i;
  logic [INT_N-1:0]  irq_ack_o;
  logic              halted_o;
  logic [ADDR_W-1:0] pc_o;

  modport master (
    output run_i, ld_we_i, ld_addr_i, ld_data_i, int_i,
    input  irq_ack_o, halted_o, pc_o
  );

  modport slave (
    input  run_i, ld_we_i, ld_addr_i, ld_data_i, int_i,
    output irq_ack_o, halted_o, pc_o
  );
endinterface

// File: rtl/up_core_vec.sv
// up_core_vec: 4-register accumulator CPU with vectored edge interrupts.
// Ports: clk, nRst (async low), bus (load port, int_i/irq_ack_o, halted_o, pc_o).
module up_core_vec #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int INT_N    = 4,
  parameter int RESET_PC = 'h10,
  parameter int VEC_BASE = 'h00
) (
  input  logic           clk,
  input  logic           nRst,
  up_core_vec_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_PUSH  = 3'd3,
    S_VEC   = 3'd4,
    S_HALT  = 3'd5
  } state_e;

  state_e           state_q, state_d;
  addr_t            pc_q, pc_d;
  addr_t            sp_q, sp_d;
  data_t            rf_q [4];
  data_t            rf_d [4];
  data_t            ir_q, ir_d;
  logic             ie_q, ie_d;
  logic             insvc_q, insvc_d;
  logic [INT_N-1:0] pend_q, pend_d;
  logic [INT_N-1:0] iprev_q;
  logic [2:0]       vec_q, vec_d;
  logic [INT_N-1:0] ack;

  data_t mem_q [DEPTH];

  addr_t      raddr, waddr;
  data_t      rdata, wdata;
  logic       we, mem_we;
  addr_t      mem_waddr;
  data_t      mem_wdata;
  logic       take_int;
  logic [2:0] k;
  logic [3:0] op;
  addr_t      r3a, sp_inc;
  logic       unused;

  assign op       = ir_q[DATA_W-1 -: 4];
  assign r3a      = rf_q[3][ADDR_W-1:0];
  assign sp_inc   = sp_q + addr_t'(1);
  assign rdata    = mem_q[raddr];
  assign take_int = ie_q & ~insvc_q & (|pend_q);
  assign unused   = ^{ir_q, rf_q[3], rdata, rf_q[0]};

  // lowest pending index wins
  always_comb begin
    k = '0;
    for (int i = INT_N - 1; i >= 0; i--) begin
      if (pend_q[i]) k = 3'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    rf_d    = rf_q;
    ir_d    = ir_q;
    ie_d    = ie_q;
    insvc_d = insvc_q;
    vec_d   = vec_q;
    ack     = '0;
    we      = 1'b0;
    waddr   = sp_q;
    wdata   = data_t'(pc_q);
    raddr   = pc_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.run_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (!bus.run_i) begin
          state_d = S_IDLE;
        end else if (take_int) begin
          state_d = S_PUSH;
        end else begin
          ir_d    = rdata;
          pc_d    = pc_q + addr_t'(1);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        unique case (op)
          4'h0: rf_d[1] = rf_q[1] + rf_q[2];
          4'h1: rf_d[1] = rf_q[1] - rf_q[2];
          4'h2: rf_d[1] = rf_q[1] * rf_q[2];
          4'h3: rf_d[1] = ~(rf_q[1] & rf_q[2]);
          4'h4: rf_d[1] = rf_q[1] ^ rf_q[2];
          4'h5: begin
            rf_d[3] = rdata;
            pc_d    = pc_q + addr_t'(1);
          end
          4'h6: begin
            raddr   = r3a;
            rf_d[2] = rdata;
          end
          4'h7: begin
            we    = 1'b1;
            waddr = r3a;
            wdata = rf_q[2];
          end
          4'h8: begin
            if (rf_q[1] == rf_q[2]) pc_d = r3a;
          end
          4'h9: begin
            we   = 1'b1;
            sp_d = sp_q - addr_t'(1);
            pc_d = r3a;
          end
          4'hA: begin
            raddr = sp_inc;
            pc_d  = rdata[ADDR_W-1:0];
            sp_d  = sp_inc;
          end
          4'hB: begin
            we    = 1'b1;
            wdata = rf_q[2];
            sp_d  = sp_q - addr_t'(1);
          end
          4'hC: begin
            raddr   = sp_inc;
            rf_d[2] = rdata;
            sp_d    = sp_inc;
          end
          4'hD: begin
            raddr   = sp_inc;
            pc_d    = rdata[ADDR_W-1:0];
            sp_d    = sp_inc;
            insvc_d = 1'b0;
          end
          4'hE: ie_d = ir_q[0];
          4'hF: state_d = S_HALT;
        endcase
      end
      S_PUSH: begin
        we      = 1'b1;
        sp_d    = sp_q - addr_t'(1);
        ack     = INT_N'(1) << k;
        vec_d   = k;
        state_d = S_VEC;
      end
      S_VEC: begin
        pc_d    = addr_t'(VEC_BASE) + addr_t'(vec_q);
        insvc_d = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (take_int) state_d = S_PUSH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // a fresh edge beats the clear of the same bit
  assign pend_d = (pend_q & ~ack) | (bus.int_i & ~iprev_q);

  // core writes take precedence; the load port only acts while stopped
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    if (we) begin
      mem_we = nRst;
    end else if (!bus.run_i && bus.ld_we_i) begin
      mem_we    = nRst;
      mem_waddr = bus.ld_addr_i;
      mem_wdata = bus.ld_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= S_IDLE;
      pc_q    <= addr_t'(RESET_PC);
      sp_q    <= '1;
      rf_q    <= '{default: '0};
      ir_q    <= '0;
      ie_q    <= 1'b0;
      insvc_q <= 1'b0;
      pend_q  <= '0;
      iprev_q <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      rf_q    <= rf_d;
      ir_q    <= ir_d;
      ie_q    <= ie_d;
      insvc_q <= insvc_d;
      pend_q  <= pend_d;
      iprev_q <= bus.int_i;
      vec_q   <= vec_d;
    end
  end

  assign bus.irq_ack_o = ack;
  assign bus.halted_o  = (state_q == S_HALT);
  assign bus.pc_o      = pc_q;
endmodule

// File: tb/tb_up_core_vec.sv
// tb_up_core_vec: directed programs with a queued expectation scoreboard.
// Covers ALU, stack, priority, masking/nesting, HALT, reset and load port.
module tb_up_core_vec;
  logic clk = 1'b0;
  logic nRst = 1'b0;
  always #5 clk = ~clk;

  up_core_vec_if #(.DATA_W(8), .ADDR_W(8), .INT_N(4)) bus ();

  up_core_vec #(
    .DATA_W(8), .ADDR_W(8), .INT_N(4),
    .RESET_PC('h10), .VEC_BASE('h00)
  ) dut (
    .clk(clk),
    .nRst(nRst),
    .bus(bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t       sb[$];
  int         n_chk = 0;
  int         n_fail = 0;
  logic [3:0] acc;

  task automatic push_exp(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty got %0h want queued value", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.v) else begin
      n_fail++;
      $error("FAIL %s got %0h want %0h", e.tag, obs, e.v);
    end
  endtask

  task automatic run_to(input logic [7:0] a, input int budget);
    acc = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      acc = acc | bus.irq_ack_o;
      if (dut.state_q == 3'd1 && bus.pc_o == a) break;
    end
    pop_chk(32'(bus.pc_o));
  endtask

  task automatic wait_ack(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.irq_ack_o != 4'b0) break;
    end
    pop_chk(32'(bus.irq_ack_o));
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.halted_o) break;
    end
    pop_chk(32'(bus.halted_o));
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    bus.ld_addr_i = a;
    bus.ld_data_i = d;
    bus.ld_we_i   = 1'b1;
    @(negedge clk);
    bus.ld_we_i   = 1'b0;
  endtask

  task automatic do_reset();
    bus.run_i = 1'b0;
    nRst = 1'b0;
    @(negedge clk);
    nRst = 1'b1;
  endtask

  initial begin
    bus.run_i     = 1'b0;
    bus.ld_we_i   = 1'b0;
    bus.ld_addr_i = '0;
    bus.ld_data_i = '0;
    bus.int_i     = '0;

    // reset state
    push_exp("rst_pc", 'h10);
    push_exp("rst_halted", 0);
    push_exp("rst_ack", 0);
    push_exp("rst_sp", 'hFF);
    push_exp("rst_r1", 0);
    @(negedge clk);
    pop_chk(32'(bus.pc_o));
    pop_chk(32'(bus.halted_o));
    pop_chk(32'(bus.irq_ack_o));
    pop_chk(32'(dut.sp_q));
    pop_chk(32'(dut.rf_q[1]));
    nRst = 1'b1;

    // ALU, LD/LDI, ST and taken JZ into a stored HALT
    load('h80, 'hF0); load('h81, 'h20); load('h82, 'hFF);
    load('h10, 'h50); load('h11, 'h80); load('h12, 'h60);
    load('h13, 'h00); load('h14, 'h50); load('h15, 'h81);
    load('h16, 'h60); load('h17, 'h00); load('h18, 'h10);
    load('h19, 'h00); load('h1A, 'h20); load('h1B, 'h50);
    load('h1C, 'h82); load('h1D, 'h60); load('h1E, 'h00);
    load('h1F, 'h30); load('h20, 'h40); load('h21, 'h50);
    load('h22, 'h90); load('h23, 'h70); load('h24, 'h80);
    push_exp("pc18", 'h18); push_exp("add", 'h10);
    push_exp("pc19", 'h19); push_exp("sub", 'hF0);
    push_exp("pc1A", 'h1A); push_exp("add2", 'h10);
    push_exp("pc1B", 'h1B); push_exp("mul", 'h00);
    push_exp("pc1F", 'h1F); push_exp("add3", 'hFF);
    push_exp("pc20", 'h20); push_exp("nand", 'h00);
    push_exp("pc21", 'h21); push_exp("xor", 'hFF);
    push_exp("jz_halt", 1); push_exp("jz_pc", 'h91);
    push_exp("st_mem", 'hFF);
    bus.run_i = 1'b1;
    run_to('h18, 40); pop_chk(32'(dut.rf_q[1]));
    run_to('h19, 40); pop_chk(32'(dut.rf_q[1]));
    run_to('h1A, 40); pop_chk(32'(dut.rf_q[1]));
    run_to('h1B, 40); pop_chk(32'(dut.rf_q[1]));
    run_to('h1F, 40); pop_chk(32'(dut.rf_q[1]));
    run_to('h20, 40); pop_chk(32'(dut.rf_q[1]));
    run_to('h21, 40); pop_chk(32'(dut.rf_q[1]));
    wait_halt(40);
    pop_chk(32'(bus.pc_o));
    pop_chk(32'(dut.mem_q[8'h90]));

    // CALL/RET, stack wrap, HALT with ie=0
    do_reset();
    load('h10, 'h50); load('h11, 'h40); load('h12, 'hE0);
    load('h13, 'h90); load('h40, 'hA0); load('h14, 'hC0);
    load('h15, 'hB0); load('h16, 'hF0);
    push_exp("pc40", 'h40); push_exp("call_mem", 'h14);
    push_exp("call_sp", 'hFE);
    push_exp("pc14", 'h14); push_exp("ret_sp", 'hFF);
    push_exp("pc15", 'h15); push_exp("pop_sp", 'h00);
    push_exp("pc16", 'h16); push_exp("push_sp", 'hFF);
    push_exp("halt_ie0", 1); push_exp("halt_pc", 'h17);
    bus.run_i = 1'b1;
    run_to('h40, 40);
    pop_chk(32'(dut.mem_q[8'hFF]));
    pop_chk(32'(dut.sp_q));
    run_to('h14, 20); pop_chk(32'(dut.sp_q));
    run_to('h15, 20); pop_chk(32'(dut.sp_q));
    run_to('h16, 20); pop_chk(32'(dut.sp_q));
    repeat (1000) @(negedge clk);
    pop_chk(32'(bus.halted_o));
    pop_chk(32'(bus.pc_o));

    // fixed priority on simultaneous edges
    do_reset();
    load('h00, 'hD0); load('h01, 'hD0);
    load('h02, 'hD0); load('h03, 'hD0);
    load('h10, 'hE1); load('h11, 'h50);
    load('h12, 'h13); load('h13, 'h80);
    push_exp("pc13", 'h13);
    push_exp("ack1", 'b0010); push_exp("vec1", 'h01);
    push_exp("int_mem", 'h13);
    push_exp("ack2", 'b0100); push_exp("vec2", 'h02);
    push_exp("isr_sp", 'hFE);
    push_exp("ret13", 'h13); push_exp("reti_sp", 'hFF);
    bus.run_i = 1'b1;
    run_to('h13, 40);
    bus.int_i = 4'b0110;
    wait_ack(20);
    run_to('h01, 20);
    pop_chk(32'(dut.mem_q[8'hFF]));
    wait_ack(20);
    run_to('h02, 20);
    pop_chk(32'(dut.sp_q));
    run_to('h13, 20);
    pop_chk(32'(dut.sp_q));
    bus.int_i = 4'b0000;

    // masking with ie=0, then IE, and no nesting
    do_reset();
    load('h10, 'hE0); load('h11, 'hE0); load('h12, 'hE0);
    load('h13, 'hE1); load('h14, 'h50); load('h15, 'h16);
    load('h16, 'h80);
    bus.int_i = 4'b0001;
    @(negedge clk);
    bus.int_i = 4'b0000;
    @(negedge clk);
    push_exp("mask_pc13", 'h13); push_exp("mask_noack", 0);
    push_exp("mask_pend", 'b0001);
    push_exp("ie_ack", 'b0001); push_exp("vec0", 'h00);
    push_exp("ie_push", 'h14);
    push_exp("nest_pc14", 'h14); push_exp("nest_noack", 0);
    push_exp("nest_pend", 'b1000);
    push_exp("ack3", 'b1000); push_exp("vec3", 'h03);
    bus.run_i = 1'b1;
    run_to('h13, 40);
    pop_chk(32'(acc));
    pop_chk(32'(dut.pend_q));
    wait_ack(20);
    run_to('h00, 20);
    pop_chk(32'(dut.mem_q[8'hFF]));
    bus.int_i = 4'b1000;
    run_to('h14, 20);
    pop_chk(32'(acc));
    pop_chk(32'(dut.pend_q));
    wait_ack(20);
    run_to('h03, 20);
    bus.int_i = 4'b0000;

    // HALT woken by an interrupt
    do_reset();
    load('h10, 'hE1); load('h11, 'hF0); load('h12, 'h50);
    load('h13, 'h14); load('h14, 'h80);
    push_exp("halt", 1);
    push_exp("halt_pc_frz", 'h12); push_exp("halt_hold", 1);
    push_exp("wake_ack", 'b0001); push_exp("wake_halted", 0);
    push_exp("wake_vec", 'h00); push_exp("wake_mem", 'h12);
    push_exp("wake_ret", 'h14);
    bus.run_i = 1'b1;
    wait_halt(40);
    repeat (5) @(negedge clk);
    pop_chk(32'(bus.pc_o));
    pop_chk(32'(bus.halted_o));
    bus.int_i = 4'b0001;
    @(negedge clk);
    bus.int_i = 4'b0000;
    wait_ack(20);
    pop_chk(32'(bus.halted_o));
    run_to('h00, 20);
    pop_chk(32'(dut.mem_q[8'hFF]));
    run_to('h14, 40);

    // reset mid-CALL, then load port gated by run_i
    do_reset();
    load('hFF, 'h5A);
    load('h10, 'h50); load('h11, 'h40); load('h12, 'h90);
    push_exp("rc_pc12", 'h12);
    push_exp("rc_pc", 'h10); push_exp("rc_sp", 'hFF);
    push_exp("rc_halted", 0); push_exp("rc_nowrite", 'h5A);
    push_exp("ld_ok", 'h3C);
    push_exp("lp_pc12", 'h12); push_exp("ld_ignored", 'h3C);
    bus.run_i = 1'b1;
    run_to('h12, 40);
    @(negedge clk);
    nRst = 1'b0;
    #1;
    pop_chk(32'(bus.pc_o));
    pop_chk(32'(dut.sp_q));
    pop_chk(32'(bus.halted_o));
    @(negedge clk);
    pop_chk(32'(dut.mem_q[8'hFF]));
    bus.run_i = 1'b0;
    nRst = 1'b1;
    load('h10, 'h50); load('h11, 'h12); load('h12, 'h80);
    load('h80, 'h3C);
    pop_chk(32'(dut.mem_q[8'h80]));
    bus.run_i = 1'b1;
    run_to('h12, 40);
    bus.ld_addr_i = 8'h80;
    bus.ld_data_i = 8'h77;
    bus.ld_we_i   = 1'b1;
    repeat (3) @(negedge clk);
    bus.ld_we_i   = 1'b0;
    pop_chk(32'(dut.mem_q[8'h80]));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
